// File: rtl/mmio_io_port.sv
// Memory-mapped I/O port: two seven-segment digit registers written from the
// store path, plus a synchronized, debounced button array read on the load path.
module mmio_io_port #(
  parameter int data_width      = 32,
  parameter int num_buttons     = 4,
  parameter int debounce_cycles = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             sel_mux_data_in,
  input  logic [4:0]             sel_mux_data_out,
  input  logic [data_width-1:0]  wr_data,
  input  logic [num_buttons-1:0] btn_raw,
  output logic [6:0]             seg0,
  output logic [6:0]             seg1,
  output logic [data_width-1:0]  rd_data,
  output logic                   btn_irq
);

  localparam int               cnt_w   = $clog2(debounce_cycles);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(debounce_cycles - 1);
  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

  logic [4:0]             wr_data_q_r;
  logic [4:0]             dig0_r;
  logic [4:0]             dig1_r;
  logic [num_buttons-1:0] sync1_r;
  logic [num_buttons-1:0] sync2_r;
  logic [num_buttons-1:0] stable_r;
  logic [num_buttons-1:0] stable_s;
  logic [num_buttons-1:0] pending_r;
  logic [num_buttons-1:0] pending_s;
  logic [num_buttons-1:0] rise_s;
  logic [cnt_w-1:0]       cnt_r [num_buttons];
  logic [cnt_w-1:0]       cnt_s [num_buttons];
  logic                   rd_sel_s;
  logic                   unused_wr_s;

  // Only {blank, nibble} of the store data is ever consumed.
  assign unused_wr_s = ^wr_data[data_width-1:5];

  function automatic logic [6:0] seg_decode(input logic [4:0] dig);
    logic [6:0] seg;
    if (dig[4]) begin
      seg = 7'b1111111;
    end else begin
      case (dig[3:0])
        4'h0:    seg = 7'b1000000;
        4'h1:    seg = 7'b1111001;
        4'h2:    seg = 7'b0100100;
        4'h3:    seg = 7'b0110000;
        4'h4:    seg = 7'b0011001;
        4'h5:    seg = 7'b0010010;
        4'h6:    seg = 7'b0000010;
        4'h7:    seg = 7'b1111000;
        4'h8:    seg = 7'b0000000;
        4'h9:    seg = 7'b0010000;
        4'hA:    seg = 7'b0001000;
        4'hB:    seg = 7'b0000011;
        4'hC:    seg = 7'b1000110;
        4'hD:    seg = 7'b0100001;
        4'hE:    seg = 7'b0000110;
        4'hF:    seg = 7'b0001110;
        default: seg = 7'b1111111;
      endcase
    end
    return seg;
  endfunction

  assign seg0    = seg_decode(dig0_r);
  assign seg1    = seg_decode(dig1_r);
  assign btn_irq = |pending_r;

  // Store data is delayed one cycle to line up with the controller's registered select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_data_q_r <= 5'b00000;
      dig0_r      <= 5'b10000;
      dig1_r      <= 5'b10000;
    end else begin
      wr_data_q_r <= wr_data[4:0];
      case (sel_mux_data_in)
        5'd1:    dig0_r <= wr_data_q_r;
        5'd2:    dig1_r <= wr_data_q_r;
        default: ;
      endcase
    end
  end

  // Debounce counters, stable state and press capture; a new press wins over a read clear.
  always_comb begin
    rd_sel_s  = (sel_mux_data_out == 5'd1);
    stable_s  = stable_r;
    rise_s    = '0;
    pending_s = pending_r;
    for (int i = 0; i < num_buttons; i++) begin
      cnt_s[i] = cnt_r[i];
      if (sync2_r[i] == stable_r[i]) begin
        cnt_s[i] = '0;
      end else if (cnt_r[i] == cnt_max) begin
        stable_s[i] = sync2_r[i];
        cnt_s[i]    = '0;
      end else begin
        cnt_s[i] = cnt_r[i] + cnt_one;
      end
    end
    rise_s = stable_s & ~stable_r;
    if (rd_sel_s) begin
      pending_s = rise_s;
    end else begin
      pending_s = pending_r | rise_s;
    end
  end

  // Synchronizer, debounce and pending state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r   <= '0;
      sync2_r   <= '0;
      stable_r  <= '0;
      pending_r <= '0;
      for (int i = 0; i < num_buttons; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      sync1_r   <= btn_raw;
      sync2_r   <= sync1_r;
      stable_r  <= stable_s;
      pending_r <= pending_s;
      for (int i = 0; i < num_buttons; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

  // Load data: stable buttons in the low byte, pending presses in the next byte.
  always_comb begin
    rd_data = '0;
    if (rd_sel_s) begin
      rd_data[num_buttons-1:0]  = stable_r;
      rd_data[8 +: num_buttons] = pending_r;
    end else begin
      rd_data = '0;
    end
  end

endmodule
